// File: rtl/serial_rcs_pkg.sv
// rtl/serial_rcs_pkg.sv - shared types and constants for the bit-serial ripple-borrow subtractor
package serial_rcs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rcs_state_e;

    localparam int RCS_W = 4;

endpackage

// File: rtl/serial_rcs_fs1.sv
// rtl/serial_rcs_fs1.sv - combinational 1-bit full subtractor (a - b - c)
module serial_rcs_fs1 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic bo
);

    assign diff = a ^ b ^ c;
    assign bo   = (~a & b) | (~a & c) | (b & c);

endmodule

// File: rtl/serial_rcs.sv
// rtl/serial_rcs.sv - bit-serial subtractor d = x - y - bin, one bit per clock, valid/ready on both sides
module serial_rcs
    import serial_rcs_pkg::*;
#(
    parameter  int W  = RCS_W,
    localparam int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] d,
    output logic         bout,
    output logic         busy
);

    rcs_state_e    state;
    logic [W-1:0]  xs;
    logic [W-1:0]  ys;
    logic [W-1:0]  ds;
    logic          br;
    logic [CW-1:0] cnt;
    logic          diff;
    logic          bo;

    serial_rcs_fs1 u_fs1 (
        .a    (xs[0]),
        .b    (ys[0]),
        .c    (br),
        .diff (diff),
        .bo   (bo)
    );

    assign in_ready = (state == IDLE) && rst_n;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            xs        <= '0;
            ys        <= '0;
            ds        <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            d         <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // d/bout keep the previous result until the next one lands
                    if (in_valid) begin
                        xs    <= x;
                        ys    <= y;
                        br    <= bin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    ds  <= {diff, ds[W-1:1]};
                    xs  <= xs >> 1;
                    ys  <= ys >> 1;
                    br  <= bo;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        d         <= {diff, ds[W-1:1]};
                        bout      <= bo;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rcs.sv
// tb/tb_serial_rcs.sv - scoreboard bench for serial_rcs at W=4
module tb_serial_rcs;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] d;
    logic         bout;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W:0] exp_q[$];

    serial_rcs #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] r;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
        return r;
    endfunction

    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic ba);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL issue_wait: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        x = xa;
        y = ya;
        bin = ba;
        in_valid = 1'b1;
        exp_q.push_back(model(xa, ya, ba));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        int n;
        logic [W:0] e;
        n = 0;
        in_valid = 1'b0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (!out_valid || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_valid: out_valid=%0b queued=%0d, required out_valid=1 with a queued result", tag, out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (d !== e[W-1:0]) begin
                n_fail++;
                $display("FAIL %s_d: got %b, required %b", tag, d, e[W-1:0]);
            end
            n_checks++;
            if (bout !== e[W]) begin
                n_fail++;
                $display("FAIL %s_bout: got %b, required %b", tag, bout, e[W]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0", tag, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({in_ready, out_valid, d, bout, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b d=%b bout=%b busy=%b, required all 0",
                     in_ready, out_valid, d, bout, busy);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_latency();
        int n;
        issue(4'b0010, 4'b0111, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL latency_busy: busy=%b in_ready=%b, required 1 0", busy, in_ready);
            end
            tick();
            n++;
        end
        n_checks++;
        if (n != W) begin
            n_fail++;
            $display("FAIL latency_edges: out_valid after %0d edges, required %0d", n, W);
        end
        collect("latency");
    endtask

    task automatic test_basic();
        issue(4'b0111, 4'b0010, 1'b0);
        collect("basic_pos");
        issue(4'b0000, 4'b0000, 1'b1);
        collect("basic_zero_bin");
        issue(4'b0101, 4'b0101, 1'b1);
        collect("basic_eq_bin");
        issue(4'b0000, 4'b0000, 1'b0);
        collect("basic_zero");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d0;
        logic         b0;
        issue(4'b1111, 4'b1111, 1'b0);
        while (!out_valid) tick();
        d0 = d;
        b0 = bout;
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== d0 || bout !== b0) begin
                n_fail++;
                $display("FAIL backpressure_hold: out_valid=%b in_ready=%b d=%b bout=%b, required 1 0 %b %b",
                         out_valid, in_ready, d, bout, d0, b0);
            end
        end
        collect("backpressure");
    endtask

    task automatic test_back_to_back();
        int cyc;
        int last_acc;
        int n_acc;
        logic [W:0] e;
        cyc = 0;
        last_acc = -1;
        n_acc = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        x = W'($urandom_range(15));
        y = W'($urandom_range(15));
        bin = 1'($urandom_range(1));
        while ((n_acc < 8 || exp_q.size() != 0) && cyc < 120) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if (d !== e[W-1:0] || bout !== e[W]) begin
                    n_fail++;
                    $display("FAIL b2b_result: got d=%b bout=%b, required d=%b bout=%b", d, bout, e[W-1:0], e[W]);
                end
            end
            if (in_ready && in_valid) begin
                exp_q.push_back(model(x, y, bin));
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != W + 2) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: got %0d cycles, required %0d", cyc - last_acc, W + 2);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
            tick();
            cyc++;
            if (n_acc >= 8) in_valid = 1'b0;
            x = W'($urandom_range(15));
            y = W'($urandom_range(15));
            bin = 1'($urandom_range(1));
        end
        n_checks++;
        if (exp_q.size() != 0 || n_acc != 8) begin
            n_fail++;
            $display("FAIL b2b_drain: accepted=%0d pending=%0d, required 8 0", n_acc, exp_q.size());
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_op();
        issue(4'b1010, 4'b0011, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || {out_valid, d, bout, busy} !== '0) begin
            n_fail++;
            $display("FAIL abort_state: in_ready=%b out_valid=%b d=%b bout=%b busy=%b, required 1 0 0000 0 0",
                     in_ready, out_valid, d, bout, busy);
        end
        for (int i = 0; i < W + 2; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_output: out_valid=%b at cycle %0d, required 0", out_valid, i);
            end
        end
        issue(4'b1010, 4'b0011, 1'b0);
        collect("after_abort");
    endtask

    task automatic test_ignored_input();
        issue(4'b1100, 4'b0110, 1'b1);
        for (int i = 0; i < W + 3; i++) begin
            in_valid = ~in_valid;
            x = W'($urandom_range(15));
            y = W'($urandom_range(15));
            bin = ~bin;
            tick();
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_ready: in_ready=%b at cycle %0d, required 0", in_ready, i);
            end
        end
        collect("ignore");
        for (int i = 0; i < W + 2; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_extra: out_valid=%b busy=%b, required 0 0", out_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_ignored_input();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
